msg_buffer_spi: RTL

- Parametrised, single-clock successor to the SPI input path's buffering stage.
- Accepts framed parallel words from an upstream deserializer and stores them in a DEPTH-word data buffer.
- Commits a message and its word count to a length queue only when the message is complete and fits.
- Oversized, overflowing or aborted messages are rolled back and counted. Downstream (the SYS_CLK packet parser) reads only whole committed messages.

---
 rtl/msg_buffer_spi_pkg.sv | 23 ++
 rtl/msg_buffer_spi_sync_fifo_sa.sv | 50 +++++
 rtl/msg_buffer_spi.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/msg_buffer_spi_pkg.sv
// Shared types and helpers for the SPI message buffer: FSM state encoding,
// drop counter width and a constant-evaluable ceil(log2) function.
package msg_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 8;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/msg_buffer_spi_sync_fifo_sa.sv
// Single-clock show-ahead FIFO; the head entry is visible on o_rd_data while
// not empty and reads as zero when empty. Push and pop may occur together.
module sync_fifo_sa
  import msg_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_push;
  logic             w_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (w_count == '0);
  assign o_full    = (w_count == (AW+1)'(DEPTH));
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the empty gate above hides stale entries.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/msg_buffer_spi.sv
// Message-granular SPI input buffer: words are written speculatively, then
// either committed with their length or rolled back and counted as dropped.
module msg_buffer_spi
  import msg_buffer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 512,
  parameter int LEN_DEPTH = 16,
  parameter int MAX_LEN   = 255,
  parameter int AW        = clog2(DEPTH),
  parameter int LEN_W     = clog2(MAX_LEN + 1)
) (
  input  logic                  SYS_CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     IN_DATA,
  input  logic                  IN_ENA,
  input  logic                  IN_LAST,
  input  logic                  IN_ABORT,
  input  logic                  RD_REQ,
  input  logic                  RD_REQ_LEN,
  output logic [DATA_W-1:0]     FIFO_Q,
  output logic                  GOT_FULL_MSG,
  output logic [LEN_W-1:0]      MSG_LEN_OUT,
  output logic [AW:0]           USED,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_cm_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [LEN_W-1:0]      r_wc;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic [DATA_W-1:0]     r_fifo_q;
  state_t                r_state;

  state_t                w_state_nxt;
  logic [AW:0]           w_wr_ptr_nxt;
  logic [AW:0]           w_cm_ptr_nxt;
  logic [LEN_W-1:0]      w_wc_nxt;
  logic [LEN_W-1:0]      w_len_din;
  logic [AW:0]           w_used;
  logic                  w_has_space;
  logic                  w_mem_we;
  logic                  w_len_push;
  logic                  w_len_full;
  logic                  w_len_empty;
  logic                  w_drop_inc;
  logic                  w_rd_fire;

  // Space is judged on pre-update pointers; a same-cycle read frees nothing.
  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_has_space = (w_used != (AW+1)'(DEPTH));
  assign w_rd_fire   = RD_REQ && (r_rd_ptr != r_cm_ptr);

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_cm_ptr_nxt = r_cm_ptr;
    w_wc_nxt     = r_wc;
    w_len_din    = r_wc;
    w_mem_we     = 1'b0;
    w_len_push   = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!IN_ABORT && IN_ENA) begin
          if (w_has_space) begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            w_wc_nxt     = LEN_W'(1);
            if (IN_LAST) begin
              w_len_din = LEN_W'(1);
              if (!w_len_full) begin
                w_len_push   = 1'b1;
                w_cm_ptr_nxt = r_wr_ptr + 1'b1;
              end else begin
                w_wr_ptr_nxt = r_cm_ptr;
                w_drop_inc   = 1'b1;
              end
            end else begin
              w_state_nxt = RECV;
            end
          end else begin
            w_drop_inc  = 1'b1;
            w_state_nxt = IN_LAST ? IDLE : DROP;
          end
        end
      end
      RECV: begin
        if (IN_ABORT) begin
          w_wr_ptr_nxt = r_cm_ptr;
          w_drop_inc   = 1'b1;
          w_state_nxt  = IDLE;
        end else if (IN_ENA) begin
          if (w_has_space && (r_wc < LEN_W'(MAX_LEN))) begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            w_wc_nxt     = r_wc + 1'b1;
            if (IN_LAST) begin
              w_len_din   = r_wc + 1'b1;
              w_state_nxt = IDLE;
              if (!w_len_full) begin
                w_len_push   = 1'b1;
                w_cm_ptr_nxt = r_wr_ptr + 1'b1;
              end else begin
                w_wr_ptr_nxt = r_cm_ptr;
                w_drop_inc   = 1'b1;
              end
            end
          end else begin
            w_wr_ptr_nxt = r_cm_ptr;
            w_drop_inc   = 1'b1;
            w_state_nxt  = IN_LAST ? IDLE : DROP;
          end
        end
      end
      DROP: begin
        if (IN_ABORT || (IN_ENA && IN_LAST)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wc       <= '0;
      r_drop_cnt <= '0;
      r_fifo_q   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_cm_ptr <= w_cm_ptr_nxt;
      r_wc     <= w_wc_nxt;
      if (w_drop_inc) r_drop_cnt <= sat_inc(r_drop_cnt);
      if (w_rd_fire) begin
        r_fifo_q <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // A write never targets the read slot: reads stay below cm_ptr <= wr_ptr.
  always_ff @(posedge SYS_CLK) begin
    if (w_mem_we) r_mem[r_wr_ptr[AW-1:0]] <= IN_DATA;
  end

  sync_fifo_sa #(
    .WIDTH (LEN_W),
    .DEPTH (LEN_DEPTH)
  ) u_len_q (
    .i_clk     (SYS_CLK),
    .i_rst     (RST),
    .i_wr_en   (w_len_push),
    .i_wr_data (w_len_din),
    .i_rd_en   (RD_REQ_LEN),
    .o_rd_data (MSG_LEN_OUT),
    .o_empty   (w_len_empty),
    .o_full    (w_len_full)
  );

  assign FIFO_Q       = r_fifo_q;
  assign GOT_FULL_MSG = !w_len_empty;
  assign USED         = w_used;
  assign DROP_CNT     = r_drop_cnt;

endmodule
